vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 81 ++++++++
 tb/tb_vga_sync_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides sys_clk by two into a pixel enable and produces
// registered counters, syncs, visible-window flag, vblank pulse and frame count.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        sys_clk,
  input  logic        reset,
  output logic        pix_clk_out,
  output logic        pix_en,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        bright,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [9:0] v_next;

  assign pix_clk_out = tick;
  assign pix_en      = tick;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = h_wrap ? '0 : hcount + 10'd1;
    v_next = vcount;
    if (h_wrap) v_next = v_wrap ? '0 : vcount + 10'd1;
  end

  // Syncs and bright decode the next counter values so they land with the counters.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      tick         <= 1'b0;
      hcount       <= '0;
      vcount       <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      bright       <= 1'b1;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      tick         <= ~tick;
      vblank_start <= 1'b0;
      if (tick) begin
        hcount       <= h_next;
        vcount       <= v_next;
        hsync        <= !((h_next >= HS_START) && (h_next < HS_END));
        vsync        <= !((v_next >= VS_START) && (v_next < VS_END));
        bright       <= (h_next < H_VIS) && (v_next < V_VIS);
        vblank_start <= (h_next == '0) && (v_next == V_VIS);
        if (h_wrap && v_wrap) frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen with a reduced timing set; expected outputs
// are computed from the number of sys_clk edges since reset release.
module tb_vga_sync_gen;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;  // 15
  localparam int VT = VV + VF + VS + VB;  // 10
  localparam int FR = HT * VT;            // pixels per frame

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        pix_clk_out, pix_en, hsync, vsync, bright, vblank_start;
  logic [9:0]  hcount, vcount;
  logic [15:0] frame_count;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .pix_clk_out(pix_clk_out), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .bright(bright), .vblank_start(vblank_start), .frame_count(frame_count)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passes++;
  endtask

  logic [41:0] dut_vec;
  assign dut_vec = {pix_clk_out, pix_en, hcount, vcount, hsync, vsync, bright,
                    vblank_start, frame_count};

  localparam logic [41:0] RST_VEC = {1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1,
                                     1'b0, 16'd0};

  // Expected outputs after e sys_clk edges since release; one pixel per two edges.
  function automatic logic [41:0] model(input int e, input logic [15:0] off);
    int n, h, v;
    logic [15:0] fc;
    n  = e / 2;
    h  = n % HT;
    v  = (n / HT) % VT;
    fc = 16'(off + 16'(n / FR));
    return {(e % 2) == 1, (e % 2) == 1, 10'(h), 10'(v),
            !(h >= HV + HF && h < HV + HF + HS),
            !(v >= VV + VF && v < VV + VF + VS),
            (h < HV) && (v < VV),
            (e % 2 == 0) && (e > 0) && (n % FR == VV * HT),
            fc};
  endfunction

  int          edges;
  logic [15:0] fc_off;
  logic [41:0] sb[$];

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      edges  = 0;
      fc_off = '0;
      sb.delete();
    end else begin
      edges++;
      sb.push_back(model(edges, fc_off));
    end
  end

  always @(negedge sys_clk) begin
    if (reset) check("reset_hold", 64'(dut_vec), 64'(RST_VEC));
    else if (sb.size() > 0) check("cycle", 64'(dut_vec), 64'(sb.pop_front()));
  end

  task automatic wait_pos(input int h, input int v, input string tag);
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge sys_clk);
      if (hcount == 10'(h) && vcount == 10'(v)) return;
    end
    check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic count_to_vblank(input string tag, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge sys_clk);
      n++;
      if (vblank_start) break;
    end
    check(tag, 64'(n), 64'(exp));
  endtask

  initial begin
    int hs_low, vs_low, br_hi, vb_hi;
    reset = 1'b1;
    #1 check("reset_init", 64'(dut_vec), 64'(RST_VEC));
    repeat (3) @(negedge sys_clk);
    #2 reset = 1'b0;

    // One full frame of sync/bright statistics (two sys_clk cycles per pixel).
    hs_low = 0; vs_low = 0; br_hi = 0; vb_hi = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge sys_clk);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (bright) br_hi++;
      if (vblank_start) vb_hi++;
    end
    check("hsync_low_cycles", 64'(hs_low), 64'(2 * HS * VT));
    check("vsync_low_cycles", 64'(vs_low), 64'(2 * VS * HT));
    check("bright_cycles", 64'(br_hi), 64'(2 * HV * VV));
    check("vblank_pulses", 64'(vb_hi), 64'd1);

    count_to_vblank("vblank_align", 2 * VV * HT);
    count_to_vblank("vblank_period", 2 * FR);

    wait_pos(HV - 1, VV - 1, "pos_last_vis");
    check("bright_last_vis", 64'(bright), 64'd1);
    wait_pos(HV, VV - 1, "pos_h_front");
    check("bright_h_front", 64'(bright), 64'd0);
    wait_pos(0, VV, "pos_vblank");
    check("bright_vblank", 64'(bright), 64'd0);
    wait_pos(0, 0, "pos_origin");
    check("bright_origin", 64'(bright), 64'd1);

    // Preload frame_count to its maximum and watch it wrap with the counters.
    @(negedge sys_clk);
    #2;
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    fc_off = 16'(16'hFFFF - 16'((edges / 2) / FR));
    check("fc_preload", 64'(frame_count), 64'hFFFF);
    wait_pos(HT - 1, VT - 1, "pos_frame_end");
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("wrap_counters", 64'({hcount, vcount}), 64'd0);
    check("wrap_frame_count", 64'(frame_count), 64'd0);

    wait_pos(5, 3, "pos_mid");
    #2 reset = 1'b1;
    #1 check("reset_async", 64'(dut_vec), 64'(RST_VEC));
    repeat (3) @(negedge sys_clk);
    #2 reset = 1'b0;
    count_to_vblank("vblank_after_reset", 2 * VV * HT);
    check("fc_after_reset", 64'(frame_count), 64'd0);

    repeat (2 * FR + 20) @(negedge sys_clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
